// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Shared constants for the 8-digit hex 7-segment scan driver.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] seg_t;

  // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always off
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_HEX_0 = 8'hC0;
  localparam seg_t SEG_HEX_1 = 8'hF9;
  localparam seg_t SEG_HEX_2 = 8'hA4;
  localparam seg_t SEG_HEX_3 = 8'hB0;
  localparam seg_t SEG_HEX_4 = 8'h99;
  localparam seg_t SEG_HEX_5 = 8'h92;
  localparam seg_t SEG_HEX_6 = 8'h82;
  localparam seg_t SEG_HEX_7 = 8'hF8;
  localparam seg_t SEG_HEX_8 = 8'h80;
  localparam seg_t SEG_HEX_9 = 8'h90;
  localparam seg_t SEG_HEX_A = 8'h88;
  localparam seg_t SEG_HEX_B = 8'h83;
  localparam seg_t SEG_HEX_C = 8'hC6;
  localparam seg_t SEG_HEX_D = 8'hA1;
  localparam seg_t SEG_HEX_E = 8'h86;
  localparam seg_t SEG_HEX_F = 8'h8E;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_hex_decode                                                      |
// | Combinational nibble to active-low 7-segment pattern.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan                                                            |
// | Time-multiplexed 8-digit hex display driver, common-anode, with a    |
// | per-frame snapshot of the displayed word.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        seg_clk,
  input  logic        segrst,
  input  logic [31:0] segdata,
  input  logic [7:0]  segen,
  input  logic        blank_lz,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_BLANK    = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_snap;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic [4:0]  w_bit_pos;
  logic [3:0]  w_nibble;
  logic [31:0] w_upper;
  logic        w_lz_blank;
  logic        w_lit;
  logic [7:0]  w_hex;
  logic [7:0]  w_an_sel;

  assign w_bit_pos  = {r_idx, 2'b00};
  assign w_nibble   = r_snap[w_bit_pos +: 4];
  assign w_upper    = r_snap >> w_bit_pos;
  // Digit 0 is exempt so an all-zero word still shows a single "0"
  assign w_lz_blank = blank_lz && (r_idx != '0) && (w_upper == 32'd0);
  assign w_lit      = (r_cnt >= c_BLANK) && segen[r_idx] && !w_lz_blank;
  assign w_an_sel   = ~(8'b0000_0001 << r_idx);

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_hex)
  );

  always_ff @(posedge seg_clk) begin
    if (segrst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_snap <= 32'd0;
      r_an   <= SEG_BLANK;
      r_seg  <= SEG_BLANK;
    end else begin
      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Load cycle is always within the blank window, so no stale digit shows
      if ((r_idx == '0) && (r_cnt == '0)) begin
        r_snap <= segdata;
      end

      r_an  <= w_lit ? w_an_sel : SEG_BLANK;
      r_seg <= w_lit ? w_hex    : SEG_BLANK;
    end
  end

  assign seg_an  = r_an;
  assign seg_out = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// Scoreboard bench for seg7_scan: a time-based reference model predicts every
// output cycle; a monitor compares the DUT against the queued predictions.
module tb_seg7_scan;

  localparam int unsigned D = 4;
  localparam int unsigned B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  en;
  logic        blz;
  logic [7:0]  an;
  logic [7:0]  sego;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
    .seg_clk  (clk),
    .segrst   (rst),
    .segdata  (data),
    .segen    (en),
    .blank_lz (blz),
    .seg_an   (an),
    .seg_out  (sego)
  );

  logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] sb_q [$];
  int unsigned m_t;
  logic [31:0] m_snap;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Predict the output that the coming clock edge will produce.
  task automatic push_expected();
    int unsigned ph, dg;
    logic [31:0] upper;
    logic [7:0]  a_exp;
    bit          lit;
    if (rst) begin
      sb_q.push_back(16'hFFFF);
      m_t    = 0;
      m_snap = 32'd0;
    end else begin
      ph    = m_t % D;
      dg    = (m_t / D) % 8;
      upper = m_snap >> (4 * dg);
      lit   = (ph >= B) && en[dg] && !(blz && dg != 0 && upper == 32'd0);
      a_exp = 8'hFF ^ (8'h01 << dg);
      if (lit) sb_q.push_back({a_exp, hex_tbl[(m_snap >> (4 * dg)) & 32'hF]});
      else     sb_q.push_back(16'hFFFF);
      if (ph == 0 && dg == 0) m_snap = data;
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic [31:0] d, input logic [7:0] e, input logic l);
    rst  = r;
    data = d;
    en   = e;
    blz  = l;
    push_expected();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [31:0] d, input logic [7:0] e, input logic l);
    for (int i = 0; i < n; i++) step(1'b0, d, e, l);
  endtask

  always @(negedge clk) begin
    logic [15:0] exp_v;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if ({an, sego} === exp_v) n_pass++;
      else $display("FAIL disp t=%0t an/seg got %h/%h exp %h/%h", $time, an, sego,
                    exp_v[15:8], exp_v[7:0]);
    end
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  re;
    logic        rl;
    rst = 1'b1; data = 32'd0; en = 8'hFF; blz = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 8'hFF, 1'b0);
    // basic scan, two frames
    run(64, 32'h12345678, 8'hFF, 1'b0);
    // store lands while digit 3 is being scanned
    run(3 * D + 1, 32'h12345678, 8'hFF, 1'b0);
    run(19 + 32, 32'hFFFFFFFF, 8'hFF, 1'b0);
    // leading-zero blanking
    run(64, 32'h000000A0, 8'hFF, 1'b1);
    run(64, 32'h00000000, 8'hFF, 1'b1);
    // per-digit enables
    run(64, 32'h12345678, 8'b0000_0101, 1'b0);
    // reset while digit 5 is lit
    run(5 * D + 2, 32'h12345678, 8'hFF, 1'b0);
    step(1'b1, 32'h12345678, 8'hFF, 1'b0);
    run(64, 32'hCAFE0123, 8'hFF, 1'b0);
    // randomized traffic
    rd = $urandom; re = 8'hFF; rl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) rd = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 31) == 0) re = 8'($urandom);
      if ($urandom_range(0, 63) == 0) rl = ~rl;
      step($urandom_range(0, 199) == 0, rd, re, rl);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d exp 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
